// File: rtl/accel_sketch_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO peripherals: register addresses
// and edge-type encodings for the input PIO.
package accel_sketch_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA = 2'd0,
    PIO_ADDR_DIR  = 2'd1,
    PIO_ADDR_MASK = 2'd2,
    PIO_ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: two-flop synchronizer followed by a debounce counter that
// only accepts a new level after it has held for DEBOUNCE_CYCLES edges.
module pio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_stable
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1     <= IDLE_LEVEL;
      r_s2     <= IDLE_LEVEL;
      r_stable <= IDLE_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/accel_sketch_pio_key_in.sv
// Avalon-MM input PIO: debounced key inputs, sticky edge capture with
// write-1-to-clear, maskable level interrupt and a registered read port.
module accel_sketch_pio_key_in
  import accel_sketch_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edgeEvent;
  logic [WIDTH-1:0] w_clearBits;
  logic             w_write;
  logic [31:0]      w_readMux;
  logic             w_unused;

  logic [WIDTH-1:0] r_stableDly;
  logic [WIDTH-1:0] r_edgeCapture;
  logic [WIDTH-1:0] r_irqMask;
  logic [31:0]      r_readData;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (in_port[gi]),
      .o_stable(w_stable[gi])
    );
  end

  assign w_rise  = w_stable & ~r_stableDly;
  assign w_fall  = ~w_stable & r_stableDly;
  assign w_write = chipselect && !write_n;
  assign w_clearBits = (w_write && (address == PIO_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = ^writedata;

  always_comb begin
    w_edgeEvent = w_rise | w_fall;
    case (EDGE_TYPE)
      EDGE_RISING:  w_edgeEvent = w_rise;
      EDGE_FALLING: w_edgeEvent = w_fall;
      default:      w_edgeEvent = w_rise | w_fall;
    endcase
  end

  always_comb begin
    w_readMux = '0;
    case (address)
      PIO_ADDR_DATA: w_readMux = 32'(w_stable);
      PIO_ADDR_DIR:  w_readMux = '0;
      PIO_ADDR_MASK: w_readMux = 32'(r_irqMask);
      PIO_ADDR_EDGE: w_readMux = 32'(r_edgeCapture);
      default:       w_readMux = '0;
    endcase
  end

  // A new edge is ORed in after the clear so it survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stableDly   <= {WIDTH{IDLE_LEVEL}};
      r_edgeCapture <= '0;
      r_irqMask     <= '0;
      r_readData    <= '0;
    end else begin
      r_stableDly   <= w_stable;
      r_edgeCapture <= (r_edgeCapture & ~w_clearBits) | w_edgeEvent;
      if (w_write && (address == PIO_ADDR_MASK)) begin
        r_irqMask <= writedata[WIDTH-1:0];
      end
      r_readData <= w_readMux;
    end
  end

  assign readdata = r_readData;
  assign irq      = |(r_edgeCapture & r_irqMask);

endmodule

// File: tb/tb_accel_sketch_pio_key_in.sv
// Self-checking bench for the input PIO: register-access vector table plus
// directed debounce, capture, clear and reset sequences.
module tb_accel_sketch_pio_key_in;

  typedef struct {
    logic        doWrite;
    logic [1:0]  wAddr;
    logic [31:0] wData;
    logic [1:0]  rAddr;
    logic [31:0] expRead;
    logic        expIrq;
  } vec_t;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [3:0]  in_port    = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  accel_sketch_pio_key_in #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick();
    data = readdata;
  endtask

  task automatic applyStimulus(input logic [3:0] value, input int cycles);
    in_port = value;
    repeat (cycles) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;

    vecs[0] = '{1'b0, 2'd0, 32'h0,        2'd0, 32'hF, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 32'h5,        2'd2, 32'h5, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 32'h0,        2'd0, 32'hF, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 32'hFF,       2'd1, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 2'd3, 32'hF,        2'd3, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 2'd2, 32'hFFFFFFFA, 2'd2, 32'hA, 1'b0};
    vecs[9] = '{1'b1, 2'd2, 32'h0,        2'd2, 32'h0, 1'b0};

    // Reset with idle inputs
    reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].doWrite) writeReg(vecs[i].wAddr, vecs[i].wData);
      readReg(vecs[i].rAddr, rd);
      checkOutput($sformatf("vec%0d_read", i), rd, vecs[i].expRead);
      checkOutput($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].expIrq));
    end

    // Bit 0 falling edge with mask bit 0 set
    writeReg(2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'hE;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 6) begin
        checkOutput("b0_data_before", readdata, 32'hF);
        checkOutput("b0_irq_before", 32'(irq), 32'h0);
      end
      if (n == 7) begin
        checkOutput("b0_data_after", readdata, 32'hE);
        checkOutput("b0_irq_after", 32'(irq), 32'h1);
      end
    end
    readReg(2'd3, rd);
    checkOutput("b0_capture", rd, 32'h1);
    writeReg(2'd3, 32'h1);
    checkOutput("b0_irq_cleared", 32'(irq), 32'h0);
    readReg(2'd3, rd);
    checkOutput("b0_capture_cleared", rd, 32'h0);

    // Bit 2 glitch of three cycles is rejected
    applyStimulus(4'hA, 3);
    applyStimulus(4'hE, 10);
    readReg(2'd0, rd);
    checkOutput("glitch_data", rd, 32'hE);
    readReg(2'd3, rd);
    checkOutput("glitch_capture", rd, 32'h0);
    checkOutput("glitch_irq", 32'(irq), 32'h0);

    // Bit 1 edge captured while masked out, then unmasked
    writeReg(2'd2, 32'h0);
    applyStimulus(4'hC, 10);
    readReg(2'd3, rd);
    checkOutput("b1_capture", rd, 32'h2);
    checkOutput("b1_irq_masked", 32'(irq), 32'h0);
    writeReg(2'd2, 32'h2);
    checkOutput("b1_irq_unmasked", 32'(irq), 32'h1);
    writeReg(2'd3, 32'h2);
    checkOutput("b1_irq_cleared", 32'(irq), 32'h0);
    readReg(2'd3, rd);
    checkOutput("b1_capture_cleared", rd, 32'h0);

    // Clear of bit 3 on the very edge its capture sets
    applyStimulus(4'h4, 6);
    writeReg(2'd3, 32'h8);
    readReg(2'd3, rd);
    checkOutput("b3_edge_wins", rd, 32'h8);
    writeReg(2'd3, 32'h8);
    readReg(2'd3, rd);
    checkOutput("b3_later_clear", rd, 32'h0);

    // Rising edges are not captured with falling edge type
    applyStimulus(4'hF, 10);
    readReg(2'd0, rd);
    checkOutput("restore_data", rd, 32'hF);
    readReg(2'd3, rd);
    checkOutput("rising_ignored", rd, 32'h0);

    // Reset mid-debounce discards the partial count
    address = 2'd3;
    applyStimulus(4'hE, 4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("midreset_readdata", readdata, 32'h0);
    checkOutput("midreset_irq", 32'(irq), 32'h0);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 7) checkOutput("midreset_capture_early", readdata, 32'h0);
      if (n == 8) checkOutput("midreset_capture_late", readdata, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
